// File: rtl/bcd_conv_arbiter.sv
// Shared sequential binary-to-BCD converter (double dabble, one bit per clock)
// arbitrated round-robin between two requesters.
module bcd_conv_arbiter #(
  parameter int unsigned BIN_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       i_req,
  input  logic [BIN_W-1:0] i_bin0,
  input  logic [BIN_W-1:0] i_bin1,
  output logic [1:0]       o_gnt,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_done_id,
  output logic [11:0]      o_bcd
);

  localparam int unsigned SrW = 12 + BIN_W;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [SrW-1:0]   r_sr, w_sr_d;
  logic [3:0]       r_cnt, w_cnt_d;
  logic             r_owner, w_owner_d;
  logic             r_last, w_last_d;
  logic [1:0]       r_gnt, w_gnt_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;
  logic             r_done_id, w_done_id_d;
  logic [11:0]      r_bcd, w_bcd_d;
  logic             w_pick;
  logic [SrW-1:0]   w_step;

  // One double-dabble step: correct each BCD digit >= 5, then shift left.
  function automatic logic [SrW-1:0] dabble(input logic [SrW-1:0] s);
    logic [SrW-1:0] t;
    t = s;
    for (int d = 0; d < 3; d++) begin
      if (t[BIN_W+4*d +: 4] >= 4'd5) t[BIN_W+4*d +: 4] = t[BIN_W+4*d +: 4] + 4'd3;
    end
    return {t[SrW-2:0], 1'b0};
  endfunction

  // On a tie the requester that was not served last wins.
  assign w_pick = (i_req == 2'b11) ? ~r_last : i_req[1];
  assign w_step = dabble(r_sr);

  always_comb begin
    w_state_d   = r_state;
    w_sr_d      = r_sr;
    w_cnt_d     = r_cnt;
    w_owner_d   = r_owner;
    w_last_d    = r_last;
    w_gnt_d     = r_gnt;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_done_id_d = r_done_id;
    w_bcd_d     = r_bcd;
    unique case (r_state)
      StIdle: begin
        if (i_req != 2'b00) begin
          w_owner_d = w_pick;
          w_sr_d    = {12'd0, (w_pick ? i_bin1 : i_bin0)};
          w_cnt_d   = 4'd0;
          w_gnt_d   = w_pick ? 2'b10 : 2'b01;
          w_busy_d  = 1'b1;
          w_state_d = StConv;
        end
      end
      StConv: begin
        w_sr_d  = w_step;
        w_cnt_d = r_cnt + 4'd1;
        if (r_cnt == 4'(BIN_W - 1)) begin
          w_done_d    = 1'b1;
          w_bcd_d     = w_step[SrW-1 -: 12];
          w_done_id_d = r_owner;
          w_last_d    = r_owner;
          w_state_d   = StDone;
        end
      end
      StDone: begin
        w_gnt_d   = 2'b00;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: begin
        w_gnt_d   = 2'b00;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_sr      <= '0;
      r_cnt     <= 4'd0;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_gnt     <= 2'b00;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_bcd     <= 12'd0;
    end else begin
      r_state   <= w_state_d;
      r_sr      <= w_sr_d;
      r_cnt     <= w_cnt_d;
      r_owner   <= w_owner_d;
      r_last    <= w_last_d;
      r_gnt     <= w_gnt_d;
      r_busy    <= w_busy_d;
      r_done    <= w_done_d;
      r_done_id <= w_done_id_d;
      r_bcd     <= w_bcd_d;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_done_id = r_done_id;
  assign o_bcd     = r_bcd;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Scoreboard bench for bcd_conv_arbiter: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done pulses.
module tb_bcd_conv_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [6:0]  bin0, bin1;
  logic [1:0]  gnt;
  logic        busy, done, done_id;
  logic [11:0] bcd;

  bcd_conv_arbiter #(.BIN_W(7)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_bin0    (bin0),
    .i_bin1    (bin1),
    .o_gnt     (gnt),
    .o_busy    (busy),
    .o_done    (done),
    .o_done_id (done_id),
    .o_bcd     (bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        id;
    logic [11:0] bcd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no result (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("done_id", int'(done_id), int'(e.id));
        chk("bcd", int'(bcd), int'(e.bcd));
        chk("gnt_at_done", int'(gnt), e.id ? 2 : 1);
      end
    end
  end

  task automatic expect_res(input int c, input logic id, input logic [11:0] b);
    exp_t x;
    x.cyc = c;
    x.id  = id;
    x.bcd = b;
    q.push_back(x);
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Single requester-0 conversion; req dropped right after the load edge.
  task automatic run0(input logic [6:0] b, input logic [11:0] exp_bcd);
    expect_res(cyc + 8, 1'b0, exp_bcd);
    bin0 = b;
    req  = 2'b01;
    @(negedge clk);
    req = 2'b00;
    chk("gnt_conv", int'(gnt), 1);
    chk("busy_conv", int'(busy), 1);
    drain();
  endtask

  initial begin
    reset = 1'b1;
    req   = 2'b00;
    bin0  = '0;
    bin1  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_bcd", int'(bcd), 0);
    repeat (5) begin
      @(negedge clk);
      chk("idle_busy", int'(busy), 0);
    end

    run0(7'd127, 12'h127);
    chk("bcd_hold", int'(bcd), 12'h127);
    run0(7'd0,   12'h000);
    run0(7'd99,  12'h099);
    run0(7'd100, 12'h100);

    // Operand change and req drop during CONV are ignored.
    expect_res(cyc + 8, 1'b0, 12'h050);
    bin0 = 7'd50;
    req  = 2'b01;
    @(negedge clk);
    req = 2'b00;
    repeat (2) @(negedge clk);
    bin0 = 7'd3;
    drain();

    // Tie straight after reset: requester 0 first, requester 1 nine cycles later.
    do_reset();
    bin0 = 7'd45;
    bin1 = 7'd78;
    expect_res(cyc + 8, 1'b0, 12'h045);
    expect_res(cyc + 17, 1'b1, 12'h078);
    req = 2'b11;
    @(negedge clk);
    req = 2'b10;
    repeat (9) @(negedge clk);
    req = 2'b00;
    drain();

    // Sustained contention alternates 0,1,0,1,0,1.
    do_reset();
    bin0 = 7'd12;
    bin1 = 7'd87;
    for (int j = 0; j < 6; j++)
      expect_res(cyc + 8 + 9 * j, j[0], j[0] ? 12'h087 : 12'h012);
    req = 2'b11;
    repeat (46) @(negedge clk);
    req = 2'b00;
    drain();

    // Abort mid-CONV, then a fresh conversion with req still high.
    do_reset();
    bin0 = 7'd100;
    expect_res(cyc + 8, 1'b0, 12'h100);
    req = 2'b01;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    q.delete();
    #1;
    chk("abort_gnt", int'(gnt), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_bcd", int'(bcd), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    expect_res(cyc + 8, 1'b0, 12'h100);
    @(negedge clk);
    req = 2'b00;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
